edge_scan_ctrl: RTL and testbench
=================================

Name: edge_scan_ctrl

Overview:
- Sequences one measurement run of the 4096-bit sticky edge-mask accumulator: clear, accumulate for a programmed window, then drain.
- Drain walks the accumulator's 32-bit readout mux (sel1 = 512-bit bank, sel2 = 32-bit word) over all 128 words.
- Each word is emitted on a valid/ready stream with its index.
- Sits between the AXI config registers (start/window/abort) and the accumulator plus readout mux.

Parameters:
- RD_LAT, 1, cycles to wait after sel1/sel2 change before sampling rd_data (1..7).
- CNT_W, 16, width of the accumulation window counter.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- start  in  1  one-cycle run request; ignored unless IDLE
- abort  in  1  terminate run from any state
- accum_cycles  in  CNT_W  accumulation window length in cycles; sampled on accepted start
- acc_clr  out  1  one-cycle clear pulse to accumulator
- acc_en  out  1  accumulator OR-enable (high only during window)
- sel1  out  3  bank select to readout mux
- sel2  out  4  word select to readout mux
- rd_data  in  32  mux output, combinational from sel1/sel2
- m_valid  out  1  output word valid
- m_ready  in  1  sink ready
- m_data  out  32  captured word
- m_index  out  7  {sel1,sel2} of m_data
- m_last  out  1  high with word index 127
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, RST=1): state IDLE. acc_clr, acc_en, m_valid, m_last, busy and done are 0. sel1, sel2, m_index and m_data are 0. Counters are 0.
- States: IDLE, CLEAR, ACCUM, SETTLE, OUT, DONE.
- IDLE: start=1 → CLEAR; latch accum_cycles into win_cnt.
- CLEAR: acc_clr=1 for exactly one cycle; sel1=sel2=0.
  - → ACCUM if win_cnt≠0, else → SETTLE.
- ACCUM: acc_en=1 every cycle; win_cnt decrements.
  - Exits to SETTLE after exactly accum_cycles cycles of acc_en high.
  - Window of 0xFFFF is legal; no wrap.
- SETTLE: sel1/sel2 hold the current word address; wait RD_LAT cycles.
  - On the final settle cycle, capture rd_data into m_data and {sel1,sel2} into m_index.
  - m_last = (index==127). → OUT.
- OUT: m_valid=1. m_data, m_index and m_last are stable until handshake (m_valid & m_ready).
  - On handshake: if index==127 → DONE. Otherwise increment {sel1,sel2} (sel2 wraps 15→0 and carries into sel1) → SETTLE.
  - m_valid drops the cycle after handshake; there are no back-to-back valid cycles.
- Per-word cost: RD_LAT+1 cycles minimum with m_ready held high.
- DONE: done=1 for one cycle; busy=0 from the next cycle → IDLE. The accumulator is NOT cleared at the end; contents persist until the next run's CLEAR.
- abort=1 in any non-IDLE state → IDLE next cycle.
  - Forces acc_en=0 and m_valid=0; no done pulse.
  - sel1/sel2 are retained.
  - abort in IDLE has no effect. abort and start together in IDLE: abort wins; start is dropped.
- start while busy is ignored; no queueing.
- acc_en and acc_clr are never high in the same cycle.

Optional Feature:
- Macro: EDGE_SCAN_SKIP_ZERO_EN.
- Defined: in SETTLE, a captured word with rd_data==0 and index≠127 is not emitted. The FSM advances directly to the next SETTLE with no m_valid cycle. Word 127 is always emitted, so m_last always terminates the stream.
- Undefined: all 128 words are emitted in order 0..127.

Test Plan:
- Reset mid-ACCUM (RST pulsed at cycle 5 of a 20-cycle window) → all outputs 0 asynchronously; state IDLE; no done.
- start, accum_cycles=10, accumulator injects mask bit 0 and bit 4095, m_ready=1 → acc_clr 1 cycle; acc_en high exactly 10 cycles; 128 words emitted. Word 0=0x00000001, word 127=0x80000000 with m_last=1; done once.
- accum_cycles=0 → CLEAR directly to SETTLE; acc_en never asserted; 128 zero words.
- m_ready low 50 cycles at index 17 → m_valid, m_data and m_index=17 held stable; sequence resumes at 18 after handshake.
- abort at index 64 in OUT → m_valid low next cycle; busy low; no done. A following start re-clears and restarts from index 0.
- EDGE_SCAN_SKIP_ZERO_EN defined, only bits 40 and 3000 set → exactly 3 words emitted: index 1 = 0x00000100, index 93 = 0x01000000, and index 127 = 0x00000000 with m_last=1.

Source files
------------

// File: rtl/edge_scan_ctrl.sv
// edge_scan_ctrl
// Sequences one measurement run of the 4096-bit sticky edge-mask accumulator.
// A run clears the accumulator, enables it for a programmed window and then
// drains all 128 32-bit words through the readout mux onto a valid/ready
// stream.
//
// Optional build macro: EDGE_SCAN_SKIP_ZERO_EN
//   defined   : all-zero words are not emitted, except word 127, which is
//               always emitted so that m_last terminates the stream
//   undefined : all 128 words are emitted in order 0..127
//
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   start         one-cycle run request, accepted only in IDLE
//   abort         terminate the run from any non-IDLE state
//   accum_cycles  window length in cycles, sampled on an accepted start
//   acc_clr       one-cycle accumulator clear
//   acc_en        accumulator OR-enable, high only during the window
//   sel1, sel2    readout mux bank / word select
//   rd_data       readout mux output (combinational from sel1/sel2)
//   m_valid, m_ready, m_data, m_index, m_last   output word stream
//   busy          high in every state except IDLE
//   done          one-cycle pulse on normal completion
module edge_scan_ctrl #(
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] accum_cycles,
   output logic             acc_clr,
   output logic             acc_en,
   output logic [2:0]       sel1,
   output logic [3:0]       sel2,
   input  logic [31:0]      rd_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [31:0]      m_data,
   output logic [6:0]       m_index,
   output logic             m_last,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      IDX_W    = 7;
   localparam int unsigned      LAT_W    = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = 7'd127;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ACCUM,
      S_SETTLE,
      S_OUT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [CNT_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] w_win_cnt;
   logic [LAT_W-1:0] r_lat_cnt;
   logic [LAT_W-1:0] w_lat_cnt;
   logic [IDX_W-1:0] r_sel;
   logic [IDX_W-1:0] w_sel;
   logic             w_capture;
   logic             w_settle_last;

   logic             r_acc_clr;
   logic             r_acc_en;
   logic             r_m_valid;
   logic [31:0]      r_m_data;
   logic [IDX_W-1:0] r_m_index;
   logic             r_m_last;
   logic             r_busy;
   logic             r_done;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, counter and capture decode
   always_comb begin
      w_next_state  = r_state;
      w_win_cnt     = r_win_cnt;
      w_lat_cnt     = r_lat_cnt;
      w_sel         = r_sel;
      w_capture     = 1'b0;
      w_settle_last = (r_lat_cnt == LAT_W'(RD_LAT - 1));

      case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_next_state = S_CLEAR;
               w_win_cnt    = accum_cycles;
               w_sel        = '0;
            end
         end
         S_CLEAR: begin
            w_lat_cnt = '0;
            if (r_win_cnt != '0) begin
               w_next_state = S_ACCUM;
            end else begin
               w_next_state = S_SETTLE;
            end
         end
         S_ACCUM: begin
            // Window ends when the count reaches zero; the full CNT_W range is usable.
            w_win_cnt = r_win_cnt - CNT_W'(1);
            w_lat_cnt = '0;
            if (r_win_cnt == CNT_W'(1)) begin
               w_next_state = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (w_settle_last) begin
`ifdef EDGE_SCAN_SKIP_ZERO_EN
               // Empty words are stepped over without a valid cycle.
               if ((rd_data == 32'h0) && (r_sel != LAST_IDX)) begin
                  w_sel     = r_sel + IDX_W'(1);
                  w_lat_cnt = '0;
               end else begin
                  w_capture    = 1'b1;
                  w_next_state = S_OUT;
               end
`else
               w_capture    = 1'b1;
               w_next_state = S_OUT;
`endif
            end else begin
               w_lat_cnt = r_lat_cnt + LAT_W'(1);
            end
         end
         S_OUT: begin
            if (m_ready) begin
               if (r_sel == LAST_IDX) begin
                  w_next_state = S_DONE;
               end else begin
                  w_sel        = r_sel + IDX_W'(1);
                  w_lat_cnt    = '0;
                  w_next_state = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase

      // Abort overrides everything except the mux address, which is kept.
      if (abort && (r_state != S_IDLE)) begin
         w_next_state = S_IDLE;
         w_sel        = r_sel;
         w_capture    = 1'b0;
      end
   end

   // Datapath and registered outputs, decoded from the next state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_win_cnt <= '0;
         r_lat_cnt <= '0;
         r_sel     <= '0;
         r_acc_clr <= 1'b0;
         r_acc_en  <= 1'b0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_index <= '0;
         r_m_last  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_win_cnt <= w_win_cnt;
         r_lat_cnt <= w_lat_cnt;
         r_sel     <= w_sel;
         r_acc_clr <= (w_next_state == S_CLEAR);
         r_acc_en  <= (w_next_state == S_ACCUM);
         r_m_valid <= (w_next_state == S_OUT);
         r_busy    <= (w_next_state != S_IDLE);
         r_done    <= (w_next_state == S_DONE);
         if (w_capture) begin
            r_m_data  <= rd_data;
            r_m_index <= r_sel;
            r_m_last  <= (r_sel == LAST_IDX);
         end
      end
   end

   assign acc_clr = r_acc_clr;
   assign acc_en  = r_acc_en;
   assign sel1    = r_sel[6:4];
   assign sel2    = r_sel[3:0];
   assign m_valid = r_m_valid;
   assign m_data  = r_m_data;
   assign m_index = r_m_index;
   assign m_last  = r_m_last;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// tb_edge_scan_ctrl
// Directed bench for edge_scan_ctrl. A behavioural sticky accumulator and
// readout mux sit around the DUT; expected stream words are derived from the
// injected mask and queued before each run, then popped on every handshake.
module tb_edge_scan_ctrl;

   localparam int unsigned CNT_W = 16;

   typedef struct packed {
      logic [6:0]  idx;
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RST;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] accum_cycles;
   logic             acc_clr;
   logic             acc_en;
   logic [2:0]       sel1;
   logic [3:0]       sel2;
   logic [31:0]      rd_data;
   logic             m_valid;
   logic             m_ready;
   logic [31:0]      m_data;
   logic [6:0]       m_index;
   logic             m_last;
   logic             busy;
   logic             done;

   logic [4095:0]    acc = {128{32'hDEADBEEF}};
   logic [4095:0]    inj;
   logic [4095:0]    mask_v;
   logic [6:0]       rd_addr;

   exp_t             exp_q[$];
   int               n_vec;
   int               n_err;
   int               en_cnt;
   int               clr_cnt;
   int               done_cnt;
   int               both_cnt;

   edge_scan_ctrl #(
      .RD_LAT (1),
      .CNT_W  (CNT_W)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .abort        (abort),
      .accum_cycles (accum_cycles),
      .acc_clr      (acc_clr),
      .acc_en       (acc_en),
      .sel1         (sel1),
      .sel2         (sel2),
      .rd_data      (rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_index      (m_index),
      .m_last       (m_last),
      .busy         (busy),
      .done         (done)
   );

   always #5 CLK = ~CLK;

   // Sticky accumulator and combinational readout mux
   always @(posedge CLK) begin
      if (acc_clr) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= acc | inj;
      end
   end

   assign rd_addr = {sel1, sel2};
   assign rd_data = acc[32*int'(rd_addr) +: 32];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // One clock; samples the cycle that follows the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (acc_en) en_cnt++;
      if (acc_clr) clr_cnt++;
      if (done) done_cnt++;
      if (acc_en && acc_clr) both_cnt++;
   endtask

   task automatic load_expect(input logic [4095:0] mask);
      exp_q.delete();
      for (int i = 0; i < 128; i++) begin
         exp_t e;
         e.idx  = 7'(i);
         e.data = mask[i*32 +: 32];
         e.last = (i == 127);
`ifdef EDGE_SCAN_SKIP_ZERO_EN
         if ((e.data == 32'h0) && (i != 127)) continue;
`endif
         exp_q.push_back(e);
      end
   endtask

   task automatic do_run(input int n_cyc, input logic [4095:0] inj_in,
                         input int stall_idx, input int abort_idx);
      int   stall_left;
      int   budget;
      bit   aborted;
      exp_t e;
      inj = inj_in;
      load_expect((n_cyc > 0) ? inj_in : '0);
      en_cnt     = 0;
      clr_cnt    = 0;
      done_cnt   = 0;
      both_cnt   = 0;
      stall_left = 50;
      aborted    = 1'b0;
      budget     = 0;
      accum_cycles = CNT_W'(n_cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      while ((done_cnt == 0) && !aborted && (budget < 5000)) begin
         budget++;
         m_ready = 1'b1;
         abort   = 1'b0;
         if (m_valid) begin
            if (int'(m_index) == abort_idx) begin
               abort   = 1'b1;
               m_ready = 1'b0;
               aborted = 1'b1;
            end else if ((int'(m_index) == stall_idx) && (stall_left > 0)) begin
               m_ready = 1'b0;
               start   = (stall_left == 50);
               stall_left--;
               check("stall_index", 32'(m_index), 32'(stall_idx));
               if (exp_q.size() > 0) check("stall_data", m_data, exp_q[0].data);
            end
            if (m_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", 32'(m_index), 32'h80);
               end else begin
                  e = exp_q.pop_front();
                  check("word_index", 32'(m_index), 32'(e.idx));
                  check("word_data", m_data, e.data);
                  check("word_last", 32'(m_last), 32'(e.last));
               end
            end
         end
         tick();
         start = 1'b0;
      end
      if (budget >= 5000) check("run_timeout", 32'(budget), 32'd0);
      if (aborted) begin
         abort = 1'b0;
         check("abort_valid_drop", 32'(m_valid), 32'd0);
         check("abort_busy_drop", 32'(busy), 32'd0);
         check("abort_sel_kept", 32'({sel1, sel2}), 32'(abort_idx));
         repeat (3) tick();
         check("abort_no_done", 32'(done_cnt), 32'd0);
         check("abort_acc_en", 32'(acc_en), 32'd0);
         exp_q.delete();
      end else begin
         check("done_pulses", 32'(done_cnt), 32'd1);
         check("words_left", 32'(exp_q.size()), 32'd0);
         check("acc_en_cycles", 32'(en_cnt), 32'(n_cyc));
         check("acc_clr_cycles", 32'(clr_cnt), 32'd1);
         check("clr_en_overlap", 32'(both_cnt), 32'd0);
         tick();
         check("busy_after_done", 32'(busy), 32'd0);
         check("done_width", 32'(done), 32'd0);
      end
      m_ready = 1'b0;
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      start        = 1'b0;
      abort        = 1'b0;
      m_ready      = 1'b0;
      accum_cycles = '0;
      inj          = '0;
      RST          = 1'b0;
      #1;
      RST = 1'b1;
      #2;
      check("rst_acc_clr", 32'(acc_clr), 32'd0);
      check("rst_acc_en", 32'(acc_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_sel", 32'({sel1, sel2}), 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      tick();

      // Abort and start together in IDLE: abort wins.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check("idle_abort_start_busy", 32'(busy), 32'd0);
      check("idle_abort_start_clr", 32'(acc_clr), 32'd0);

      // Bits 0 and 4095, 10-cycle window.
      mask_v = '0;
      mask_v[0]    = 1'b1;
      mask_v[4095] = 1'b1;
      do_run(10, mask_v, -1, -1);

      // Zero window: accumulator is cleared and never enabled.
      mask_v = '0;
      mask_v[7] = 1'b1;
      do_run(0, mask_v, -1, -1);

      // Sink stalls 50 cycles on word 17; a start during the stall is ignored.
      mask_v = '0;
      mask_v[17*32+5] = 1'b1;
      mask_v[18*32]   = 1'b1;
      do_run(3, mask_v, 17, -1);

      // Abort while word 64 is offered, then a fresh run.
      mask_v = '0;
      mask_v[64*32+1] = 1'b1;
      do_run(2, mask_v, -1, 64);
      mask_v = '0;
      mask_v[0] = 1'b1;
      mask_v[3] = 1'b1;
      do_run(4, mask_v, -1, -1);

      // Sparse mask: bits 40 and 3000 only.
      mask_v = '0;
      mask_v[40]   = 1'b1;
      mask_v[3000] = 1'b1;
      do_run(1, mask_v, -1, -1);

      // Asynchronous reset in the middle of a 20-cycle window.
      inj = '0;
      inj[5] = 1'b1;
      accum_cycles = CNT_W'(20);
      start = 1'b1;
      tick();
      start = 1'b0;
      done_cnt = 0;
      repeat (5) tick();
      check("accum_before_rst", 32'(acc_en), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      check("mid_rst_acc_en", 32'(acc_en), 32'd0);
      check("mid_rst_acc_clr", 32'(acc_clr), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_last", 32'(m_last), 32'd0);
      check("mid_rst_index", 32'(m_index), 32'd0);
      check("mid_rst_data", m_data, 32'd0);
      check("mid_rst_sel", 32'({sel1, sel2}), 32'd0);
      #1;
      RST = 1'b0;
      repeat (4) tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_acc_en", 32'(acc_en), 32'd0);
      check("post_rst_no_done", 32'(done_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
